// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int ENTRY_W       = 32;
    localparam int INSTR_BYTES   = 4;
    localparam int PC_ALIGN_BITS = 2;

    typedef struct packed {
        logic [ENTRY_W-1:0] pc;
        logic [ENTRY_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush dominates push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic         clock,
    input  logic         nReset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_data,
    output fetch_entry_t rd_data,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, feeds a prefetch FIFO, handles redirects.
// Define FETCH_BOUNDS_CHECK_EN to halt fetch with a sticky fault past the memory end.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               Isize      = 32,
    parameter int               mem_size   = 10,
    parameter logic [Isize-1:0] RESET_PC   = 32'h0000_0000,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic             clock,
    input  logic             nReset,
    output logic [Isize-1:0] instr_addr,
    input  logic [Isize-1:0] instruction,
    input  logic             redirect_valid,
    input  logic [Isize-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Isize-1:0] out_instr,
    output logic [Isize-1:0] out_pc,
    output logic             fetch_fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if (mem_size <= PC_ALIGN_BITS || mem_size >= Isize) begin : g_bad_mem_size
        $error("instr_fetch_unit: mem_size out of range");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_fetch_unit: FIFO_DEPTH must be a power of 2, >= 2");
    end

    logic [Isize-1:0] pc_q, pc_d;
    logic [Isize-1:0] redirect_aligned;
    logic             push, pop, halted, oob;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;
    fetch_entry_t     wr_entry, rd_entry;

    assign redirect_aligned = redirect_pc & ~Isize'(2'b11);
    assign instr_addr       = pc_q;

    assign pop  = ~fifo_empty & out_ready & ~redirect_valid;
    assign push = ~redirect_valid & (~fifo_full | pop) & ~halted & ~oob;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [Isize-1:0] MEM_LIMIT = Isize'(1) << mem_size;
    logic halted_q, halted_d;

    assign oob = (pc_q >= MEM_LIMIT);

    // Sticky until a redirect (or reset) moves the PC somewhere legal.
    always_comb begin
        halted_d = halted_q | oob;
        if (redirect_valid) begin
            halted_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted      = halted_q;
    assign fetch_fault = halted_q;
`else
    assign oob         = 1'b0;
    assign halted      = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_aligned;
        end else if (push) begin
            pc_d = pc_q + Isize'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign wr_entry = '{pc: pc_q, instr: instruction};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .nReset  (nReset),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = (fifo_count != '0);
    assign out_pc    = rd_entry.pc;
    assign out_instr = rd_entry.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a queue-based scoreboard on the decode side.
module tb_instr_fetch_unit;

    logic        clock;
    logic        nReset;
    logic [31:0] instr_addr;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tgt;

    instr_fetch_unit dut (
        .clock          (clock),
        .nReset         (nReset),
        .instr_addr     (instr_addr),
        .instruction    (instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault)
    );

    // Memory holds its word index; 256 words, upper address bits alias.
    assign instruction = (instr_addr >> 2) & 32'h0000_00FF;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_q.push_back(pc);
    endtask

    // Monitor: a transfer is valid & ready without a redirect in the same cycle.
    always @(negedge clock) begin
        if (nReset && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_transfer", out_pc, 32'hDEAD_BEEF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("out_pc", out_pc, e);
                check("out_instr", out_instr, (e >> 2) & 32'h0000_00FF);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nReset         = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_instr_addr", instr_addr, 32'h0);
        check("rst_fetch_fault", {31'b0, fetch_fault}, 32'd0);

        // Streaming from reset with decode always ready.
        tick(1);
        nReset    = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
        tick(1);
        check("first_valid_latency", {31'b0, out_valid}, 32'd1);
        check("first_out_pc", out_pc, 32'h0);
        tick(8);
        out_ready = 1'b0;
        tick(1);
        check("full_valid", {31'b0, out_valid}, 32'd1);
        check("full_instr_addr", instr_addr, 32'h28);

        // Asynchronous reset with two queued entries.
        #1 nReset = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_addr", instr_addr, 32'h0);

        // Back-pressure: fill and hold, then drain.
        tick(1);
        nReset = 1'b1;
        tick(5);
        check("stall_instr_addr", instr_addr, 32'h8);
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_head_pc", out_pc, 32'h0);
        for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
        out_ready = 1'b1;
        tick(4);

        // Redirect while full and ready: handshake that cycle is not a transfer.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        expect_pc(32'h100);
        expect_pc(32'h104);
        tick(1);
        redirect_valid = 1'b0;
        check("redir_flush_valid", {31'b0, out_valid}, 32'd0);
        tick(1);
        check("redir_valid", {31'b0, out_valid}, 32'd1);
        check("redir_out_pc", out_pc, 32'h100);
        tick(2);

`ifdef FETCH_BOUNDS_CHECK_EN
        tgt = 32'h0000_03F8;
`else
        tgt = 32'hFFFF_FFFC;
`endif
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        expect_pc(tgt);
        expect_pc(tgt + 32'd4);
        tick(1);
        redirect_valid = 1'b0;
        tick(2);
        out_ready = 1'b1;
        tick(2);
        out_ready = 1'b0;
        tick(3);
`ifdef FETCH_BOUNDS_CHECK_EN
        check("halt_fault", {31'b0, fetch_fault}, 32'd1);
        check("halt_valid", {31'b0, out_valid}, 32'd0);
        check("halt_instr_addr", instr_addr, 32'h400);
`else
        check("wrap_fault", {31'b0, fetch_fault}, 32'd0);
        check("wrap_valid", {31'b0, out_valid}, 32'd1);
        check("wrap_instr_addr", instr_addr, 32'hC);
`endif

        // Redirect to zero clears any fault and fetch resumes.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        expect_pc(32'h0);
        expect_pc(32'h4);
        tick(1);
        redirect_valid = 1'b0;
        check("resume_fault", {31'b0, fetch_fault}, 32'd0);
        check("resume_valid", {31'b0, out_valid}, 32'd0);
        tick(2);
        out_ready = 1'b1;
        tick(2);
        out_ready = 1'b0;
        tick(2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
